// File: rtl/spu_pkg.sv
// Shared SPU register-file types and sizing constants.
// Imported by the register file and its write-resolve helper.
package spu_pkg;

    localparam int QUADWORD       = 128;
    localparam int REG_COUNT      = 128;
    localparam int REG_ADDR_WIDTH = 7;

    typedef enum logic {
        RF_IDLE  = 1'b0,
        RF_CLEAR = 1'b1
    } rf_state_t;

    // Registers above the populated range are treated as absent.
    function automatic logic addr_in_range(input int unsigned addr, input int unsigned cnt);
        return addr < cnt;
    endfunction

endpackage

// File: rtl/rf_wr_resolve.sv
// Combinational write-port resolver: for one address, reports whether any enabled
// write port targets it and which port (highest index) wins, with that port's data.
module rf_wr_resolve #(
    parameter int DATA_W = 128,
    parameter int ADDR_W = 7,
    parameter int NUM_WR = 2
) (
    input  logic [ADDR_W-1:0]        addr,
    input  logic [NUM_WR-1:0]        wr_en,
    input  logic [NUM_WR*ADDR_W-1:0] wr_addr,
    input  logic [NUM_WR*DATA_W-1:0] wr_data,
    output logic                     hit,
    output logic [NUM_WR-1:0]        win,
    output logic [DATA_W-1:0]        data
);

    // Ascending scan: a later (higher-index) match overrides earlier ones.
    always_comb begin
        hit  = 1'b0;
        win  = '0;
        data = '0;
        for (int w = 0; w < NUM_WR; w++) begin
            if (wr_en[w] && (wr_addr[w*ADDR_W +: ADDR_W] == addr)) begin
                hit    = 1'b1;
                win    = '0;
                win[w] = 1'b1;
                data   = wr_data[w*DATA_W +: DATA_W];
            end
        end
    end

endmodule

// File: rtl/reg_file_multiport.sv
// SPU register file: NUM_RD combinational read ports, NUM_WR prioritised write ports,
// optional same-cycle write bypass and a sequential clear engine.
module reg_file_multiport
    import spu_pkg::*;
#(
    parameter int DATA_W  = QUADWORD,
    parameter int REG_CNT = REG_COUNT,
    parameter int ADDR_W  = $clog2(REG_CNT),
    parameter int NUM_RD  = 6,
    parameter int NUM_WR  = 2,
    parameter int BYPASS  = 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
    output logic [NUM_RD*DATA_W-1:0] rd_data,
    input  logic [NUM_WR-1:0]        wr_en,
    input  logic [NUM_WR*ADDR_W-1:0] wr_addr,
    input  logic [NUM_WR*DATA_W-1:0] wr_data,
    input  logic                     clr_req,
    output logic                     clr_busy,
    output logic                     wr_collision,
    output rf_state_t                dbg_state
);

    localparam logic [ADDR_W-1:0] LAST_PTR = ADDR_W'(REG_CNT - 1);

    rf_state_t         state_q, state_d;
    logic [ADDR_W-1:0] clr_ptr_q, clr_ptr_d;
    logic              wr_collision_q;

    logic [DATA_W-1:0] mem [REG_CNT];

    logic              wr_hit      [NUM_WR];
    logic [NUM_WR-1:0] wr_win      [NUM_WR];
    logic [DATA_W-1:0] wr_res_data [NUM_WR];
    logic [NUM_WR-1:0] wr_keep;
    logic [NUM_WR-1:0] wr_clash;

    logic              rd_hit      [NUM_RD];
    logic [NUM_WR-1:0] rd_win      [NUM_RD];
    logic [DATA_W-1:0] rd_res_data [NUM_RD];

    // Handshake: clr_req is a single-cycle request accepted only in IDLE; clr_busy is the
    // not-ready indication, and while it is high clr_req and all writes are dropped.
    assign clr_busy     = (state_q == RF_CLEAR);
    assign wr_collision = wr_collision_q;
    assign dbg_state    = state_q;

    always_comb begin
        state_d   = state_q;
        clr_ptr_d = clr_ptr_q;
        unique case (state_q)
            RF_IDLE: begin
                if (clr_req) begin
                    state_d   = RF_CLEAR;
                    clr_ptr_d = '0;
                end
            end
            RF_CLEAR: begin
                clr_ptr_d = clr_ptr_q + ADDR_W'(1);
                if (clr_ptr_q == LAST_PTR) begin
                    state_d = RF_IDLE;
                end
            end
            default: state_d = RF_CLEAR;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q        <= RF_CLEAR;
            clr_ptr_q      <= '0;
            wr_collision_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            clr_ptr_q      <= clr_ptr_d;
            wr_collision_q <= !clr_busy && (|wr_clash);
        end
    end

    // A port keeps its write only if no higher-index port targets the same register.
    for (genvar w = 0; w < NUM_WR; w++) begin : g_wr
        logic [ADDR_W-1:0] waddr;
        assign waddr = wr_addr[w*ADDR_W +: ADDR_W];

        rf_wr_resolve #(
            .DATA_W (DATA_W),
            .ADDR_W (ADDR_W),
            .NUM_WR (NUM_WR)
        ) u_wr_res (
            .addr    (waddr),
            .wr_en   (wr_en),
            .wr_addr (wr_addr),
            .wr_data (wr_data),
            .hit     (wr_hit[w]),
            .win     (wr_win[w]),
            .data    (wr_res_data[w])
        );

        assign wr_keep[w]  = wr_hit[w] && wr_win[w][w] && addr_in_range(32'(waddr), REG_CNT);
        assign wr_clash[w] = wr_en[w] && wr_hit[w] && !wr_win[w][w];

        a_wr_win_onehot: assert property (@(posedge clk) disable iff (!reset)
            (wr_hit[w] == (|wr_win[w])) && $onehot0(wr_win[w]));
    end

    // The array has no reset; the clear engine is the only way it is zeroed.
    always_ff @(posedge clk) begin
        if (clr_busy) begin
            mem[clr_ptr_q] <= '0;
        end else begin
            for (int w = 0; w < NUM_WR; w++) begin
                if (wr_keep[w]) begin
                    mem[wr_addr[w*ADDR_W +: ADDR_W]] <= wr_res_data[w];
                end
            end
        end
    end

    for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
        logic [ADDR_W-1:0] raddr;
        logic              rvalid;
        assign raddr  = rd_addr[p*ADDR_W +: ADDR_W];
        assign rvalid = addr_in_range(32'(raddr), REG_CNT);

        rf_wr_resolve #(
            .DATA_W (DATA_W),
            .ADDR_W (ADDR_W),
            .NUM_WR (NUM_WR)
        ) u_rd_res (
            .addr    (raddr),
            .wr_en   (wr_en),
            .wr_addr (wr_addr),
            .wr_data (wr_data),
            .hit     (rd_hit[p]),
            .win     (rd_win[p]),
            .data    (rd_res_data[p])
        );

        assign rd_data[p*DATA_W +: DATA_W] =
            (clr_busy || !rvalid)        ? '0 :
            (BYPASS != 0 && rd_hit[p])   ? rd_res_data[p] :
                                           mem[raddr];

        a_rd_win_onehot: assert property (@(posedge clk) disable iff (!reset)
            (rd_hit[p] == (|rd_win[p])) && $onehot0(rd_win[p]));
    end

endmodule

// File: tb/tb_reg_file_multiport.sv
// Bench for reg_file_multiport: a default build (bypass on) and a scaled build
// (32-bit, 48 registers, 3 read / 1 write, bypass off) share clock and reset.
module tb_reg_file_multiport;
    import spu_pkg::*;

    localparam int DW = 128, RC = 128, AW = 7, NR = 6, NW = 2;
    localparam int SDW = 32, SRC = 48, SAW = 6, SNR = 3;

    // clock / reset
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic [NR*AW-1:0] rd_addr;
    logic [NR*DW-1:0] rd_data;
    logic [NW-1:0]    wr_en;
    logic [NW*AW-1:0] wr_addr;
    logic [NW*DW-1:0] wr_data;
    logic             clr_req, clr_busy, wr_collision;
    rf_state_t        dbg_state;

    logic [SNR*SAW-1:0] s_rd_addr;
    logic [SNR*SDW-1:0] s_rd_data;
    logic [0:0]         s_wr_en;
    logic [SAW-1:0]     s_wr_addr;
    logic [SDW-1:0]     s_wr_data;
    logic               s_clr_req, s_clr_busy, s_wr_collision;
    rf_state_t          s_dbg_state;

    reg_file_multiport #(.DATA_W(DW), .REG_CNT(RC), .ADDR_W(AW), .NUM_RD(NR), .NUM_WR(NW), .BYPASS(1)) dut (
        .clk(clk), .reset(reset), .rd_addr(rd_addr), .rd_data(rd_data), .wr_en(wr_en),
        .wr_addr(wr_addr), .wr_data(wr_data), .clr_req(clr_req), .clr_busy(clr_busy),
        .wr_collision(wr_collision), .dbg_state(dbg_state));

    reg_file_multiport #(.DATA_W(SDW), .REG_CNT(SRC), .ADDR_W(SAW), .NUM_RD(SNR), .NUM_WR(1), .BYPASS(0)) dut_s (
        .clk(clk), .reset(reset), .rd_addr(s_rd_addr), .rd_data(s_rd_data), .wr_en(s_wr_en),
        .wr_addr(s_wr_addr), .wr_data(s_wr_data), .clr_req(s_clr_req), .clr_busy(s_clr_busy),
        .wr_collision(s_wr_collision), .dbg_state(s_dbg_state));

    // scoreboard
    logic [127:0] exp_q[$];
    logic [127:0] model [RC];
    int total = 0;
    int bad = 0;

    typedef struct {
        logic [1:0]   we;
        int           wa0;
        int           wa1;
        logic [127:0] wd0;
        logic [127:0] wd1;
        int           rp;
        int           ra;
        logic [127:0] exp_rd;
        logic         exp_coll;
    } vec_t;
    vec_t vt[11];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic sb_push(input logic [127:0] v);
        exp_q.push_back(v);
    endtask

    task automatic sb_check(input string name, input logic [127:0] act);
        if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL %s: got %h expected <empty queue>", name, act);
        end else begin
            check(name, act, exp_q.pop_front());
        end
    endtask

    // driver tasks
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #3;
    endtask

    task automatic drive_idle();
        wr_en = '0;
        clr_req = 1'b0;
        s_wr_en = '0;
        s_clr_req = 1'b0;
    endtask

    task automatic set_wr(input int p, input int a, input logic [127:0] d);
        wr_en[p] = 1'b1;
        wr_addr[p*AW +: AW] = AW'(a);
        wr_data[p*DW +: DW] = d;
    endtask

    task automatic set_rd(input int p, input int a);
        rd_addr[p*AW +: AW] = AW'(a);
    endtask

    task automatic s_set_rd(input int p, input int a);
        s_rd_addr[p*SAW +: SAW] = SAW'(a);
    endtask

    function automatic logic [127:0] get_rd(input int p);
        return rd_data[p*DW +: DW];
    endfunction

    function automatic logic [127:0] s_get_rd(input int p);
        return 128'(s_rd_data[p*SDW +: SDW]);
    endfunction

    task automatic read_all_main(input string name);
        for (int b = 0; b < RC; b += NR) begin
            for (int p = 0; p < NR; p++) begin
                if (b + p < RC) begin
                    set_rd(p, b + p);
                    sb_push(model[b+p]);
                end
            end
            settle();
            for (int p = 0; p < NR; p++) begin
                if (b + p < RC) sb_check($sformatf("%s_r%0d", name, b + p), get_rd(p));
            end
            tick();
        end
    endtask

    task automatic count_busy(output int n);
        n = 0;
        while (clr_busy === 1'b1 && n < 400) begin
            n++;
            tick();
        end
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, sn;
        logic [127:0] v2, aa, fives, ones;
        v2    = 128'h00000005_00000007_0000000A_0000001F;
        aa    = {4{32'hAAAAAAAA}};
        fives = {4{32'h55555555}};
        ones  = '1;

        vt[0]  = '{2'b01,   5,   0, v2,           128'h0,       0,   5, v2,           1'b0};
        vt[1]  = '{2'b11,   3,   3, aa,           fives,        1,   3, fives,        1'b1};
        vt[2]  = '{2'b00,   0,   0, 128'h0,       128'h0,       2,   3, fives,        1'b0};
        vt[3]  = '{2'b00,   0,   0, 128'h0,       128'h0,       3,   5, v2,           1'b0};
        vt[4]  = '{2'b10,   0,   7, 128'h0,       128'h1234,    4,   7, 128'h1234,    1'b0};
        vt[5]  = '{2'b11,   9,  10, 128'hD9,      128'hDA,      5,   9, 128'hD9,      1'b0};
        vt[6]  = '{2'b00,   0,   0, 128'h0,       128'h0,       0,  10, 128'hDA,      1'b0};
        vt[7]  = '{2'b11, 127, 127, aa,           ones,         1, 127, ones,         1'b1};
        vt[8]  = '{2'b01,   0,   0, 128'h1,       128'h0,       2, 127, ones,         1'b0};
        vt[9]  = '{2'b01,   3,   0, 128'h2222,    128'h0,       3,   3, 128'h2222,    1'b0};
        vt[10] = '{2'b00,   0,   0, 128'h0,       128'h0,       4,   0, 128'h1,       1'b0};

        reset = 1'b0;
        rd_addr = '0; wr_addr = '0; wr_data = '0;
        s_rd_addr = '0; s_wr_addr = '0; s_wr_data = '0;
        drive_idle();
        for (int i = 0; i < RC; i++) model[i] = '0;

        // reset hold and release: sweep length on both builds
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", 128'(clr_busy), 128'd1);
        check("rst_coll", 128'(wr_collision), 128'd0);
        check("rst_state", 128'(dbg_state), 128'(RF_CLEAR));
        check("rst_s_busy", 128'(s_clr_busy), 128'd1);
        reset = 1'b1;
        for (int p = 0; p < NR; p++) set_rd(p, p * 20);
        n = 0;
        sn = 0;
        for (int k = 0; k < 400 && (clr_busy || s_clr_busy); k++) begin
            if (clr_busy) n++;
            if (s_clr_busy) sn++;
            if (k == 4) begin
                set_wr(0, 9, 128'hDEADBEEF);
                set_wr(1, 9, 128'hFEEDF00D);
                s_wr_en = 1'b1; s_wr_addr = 6'd5; s_wr_data = 32'h11111111;
            end
            if (k == 5) begin
                check("busy_coll", 128'(wr_collision), 128'd0);
                for (int p = 0; p < NR; p++) check($sformatf("busy_rd%0d", p), get_rd(p), 128'd0);
                check("s_busy_rd", s_get_rd(0), 128'd0);
                drive_idle();
            end
            tick();
        end
        check("rst_busy_len", 128'(n), 128'd128);
        check("s_rst_busy_len", 128'(sn), 128'd48);
        read_all_main("rst_read");

        // table: bypass, priority, collision pulse, boundaries
        for (int i = 0; i < 11; i++) begin
            drive_idle();
            if (vt[i].we[0]) set_wr(0, vt[i].wa0, vt[i].wd0);
            if (vt[i].we[1]) set_wr(1, vt[i].wa1, vt[i].wd1);
            if (vt[i].we[0]) model[vt[i].wa0] = vt[i].wd0;
            if (vt[i].we[1]) model[vt[i].wa1] = vt[i].wd1;
            set_rd(vt[i].rp, vt[i].ra);
            sb_push(vt[i].exp_rd);
            settle();
            sb_check($sformatf("vec%0d_rd", i), get_rd(vt[i].rp));
            tick();
            check($sformatf("vec%0d_coll", i), 128'(wr_collision), 128'(vt[i].exp_coll));
        end
        drive_idle();

        // scaled build: write latency without bypass, top register, out-of-range
        s_wr_en = 1'b1; s_wr_addr = 6'd5; s_wr_data = 32'hCAFE0005;
        s_set_rd(0, 5);
        sb_push(128'h0);
        settle();
        sb_check("s_nobypass", s_get_rd(0));
        tick();
        s_wr_en = 1'b0;
        sb_push(128'hCAFE0005);
        settle();
        sb_check("s_latency", s_get_rd(0));
        check("s_coll", 128'(s_wr_collision), 128'd0);
        tick();
        s_wr_en = 1'b1; s_wr_addr = 6'd47; s_wr_data = 32'h00004747;
        s_set_rd(1, 47);
        sb_push(128'h0);
        settle();
        sb_check("s_r47_same", s_get_rd(1));
        tick();
        s_wr_en = 1'b0;
        sb_push(128'h4747);
        settle();
        sb_check("s_r47_next", s_get_rd(1));
        tick();
        s_wr_en = 1'b1; s_wr_addr = 6'd50; s_wr_data = 32'hFFFFFFFF;
        s_set_rd(2, 50);
        sb_push(128'h0);
        settle();
        sb_check("s_oor_same", s_get_rd(2));
        tick();
        s_wr_en = 1'b0;
        s_set_rd(0, 2);
        sb_push(128'h0); sb_push(128'h4747); sb_push(128'h0);
        settle();
        sb_check("s_r2", s_get_rd(0));
        sb_check("s_r47_kept", s_get_rd(1));
        sb_check("s_oor_rd", s_get_rd(2));
        tick();
        s_clr_req = 1'b1;
        tick();
        s_clr_req = 1'b0;
        sn = 0;
        while (s_clr_busy === 1'b1 && sn < 400) begin
            sn++;
            tick();
        end
        check("s_clr_len", 128'(sn), 128'd48);
        s_set_rd(0, 5);
        s_set_rd(1, 47);
        sb_push(128'h0); sb_push(128'h0);
        settle();
        sb_check("s_clr_r5", s_get_rd(0));
        sb_check("s_clr_r47", s_get_rd(1));
        tick();

        // clear on request: fill, clear with writes during the sweep
        for (int i = 0; i < RC; i += 2) begin
            set_wr(0, i, 128'(i));
            set_wr(1, i + 1, 128'(i + 1));
            model[i] = 128'(i);
            model[i+1] = 128'(i + 1);
            tick();
        end
        drive_idle();
        read_all_main("fill");
        clr_req = 1'b1;
        set_wr(0, 4, 128'hBEEF);
        tick();
        drive_idle();
        n = 0;
        while (clr_busy === 1'b1 && n < 400) begin
            n++;
            if (n == 3) begin
                set_wr(0, 0, 128'h77);
                set_wr(1, 0, 128'h88);
            end
            if (n == 4) begin
                check("clr_coll_a", 128'(wr_collision), 128'd0);
                set_wr(0, 1, 128'h99);
                set_wr(1, 1, 128'hAA);
            end
            if (n == 5) begin
                check("clr_coll_b", 128'(wr_collision), 128'd0);
                drive_idle();
            end
            if (n == 50) clr_req = 1'b1;
            if (n == 51) clr_req = 1'b0;
            tick();
        end
        check("clr_len", 128'(n), 128'd128);
        for (int i = 0; i < RC; i++) model[i] = '0;
        read_all_main("clr");

        // reset in the middle of a sweep restarts it from r0
        set_wr(0, 100, 128'h64);
        set_wr(1, 0, 128'hABC);
        tick();
        drive_idle();
        clr_req = 1'b1;
        tick();
        clr_req = 1'b0;
        repeat (59) tick();
        reset = 1'b0;
        #1;
        check("midrst_busy", 128'(clr_busy), 128'd1);
        check("midrst_state", 128'(dbg_state), 128'(RF_CLEAR));
        tick();
        tick();
        reset = 1'b1;
        count_busy(n);
        check("midrst_len", 128'(n), 128'd128);
        read_all_main("midrst");

        if (exp_q.size() != 0) begin
            total++;
            bad++;
            $display("FAIL sb_leftover: got %0d entries expected 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
